// File: rtl/tube_field.sv
// tube_field: scrolling tube-column obstacle generator for the tube game.
// Tubes scroll left on each RUN tick and wrap to the back with a fresh LFSR gap.
// Emits a one-cycle pass pulse and a saturating score when a tube clears BIRD_X.
// Optional macro TUBE_SPEEDUP_EN: speed rises by one at each score multiple of 8,
// capped at MAX_SPEED; without it the speed is fixed at SPEED.
module tube_field #(
  parameter int unsigned NUM_TUBES = 4,
  parameter int unsigned XW        = 11,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned SPACING   = 200,
  parameter int unsigned TUBE_W    = 60,
  parameter int unsigned GAP_MIN   = 80,
  parameter int unsigned GAP_H     = 120,
  parameter int unsigned BIRD_X    = 160,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned MAX_SPEED = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_i,
  input  logic                    start_i,
  input  logic                    freeze_i,
  output logic [NUM_TUBES*XW-1:0] tube_x_o,
  output logic [NUM_TUBES*9-1:0]  gap_y_o,
  output logic                    pass_o,
  output logic [7:0]              score_o,
  output logic                    running_o
);

  localparam int unsigned GW  = 9;
  localparam int unsigned XW1 = XW + 1;
  localparam logic [15:0]   LFSR_MASK = 16'hB400;
  localparam logic [XW-1:0] WRAP_ADD  = XW'(NUM_TUBES * SPACING);
  localparam logic [XW-1:0] SPEED_X   = XW'(SPEED);
  localparam logic [XW:0]   TUBE_W_X  = XW1'(TUBE_W);
  localparam logic [XW:0]   BIRD_X_X  = XW1'(BIRD_X);

  // Reject parameter sets that break wrap spacing, x range or gap geometry.
  if ((SPACING <= MAX_SPEED) || (SCREEN_W + NUM_TUBES * SPACING >= (1 << XW)) ||
      (GAP_MIN + 128 + GAP_H > SCREEN_H) || (GAP_MIN + 32 * NUM_TUBES > 511)) begin : g_bad_cfg
    $error("tube_field: invalid parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q   [NUM_TUBES];
  logic [XW-1:0]   x_d   [NUM_TUBES];
  logic [GW-1:0]   gap_q [NUM_TUBES];
  logic [GW-1:0]   gap_d [NUM_TUBES];
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      score_q, score_d;
  logic            pass_q, pass_d;
  logic            running_q, running_d;
  logic            any_pass;
  logic [XW-1:0]   speed;

`ifdef TUBE_SPEEDUP_EN
  localparam logic [XW-1:0] MAX_SPEED_X = XW'(MAX_SPEED);
  logic [XW-1:0] speed_q, speed_d;

  // Current scroll speed, bumped on score milestones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) speed_q <= SPEED_X;
    else     speed_q <= speed_d;
  end
  assign speed = speed_q;
`else
  assign speed = SPEED_X;
`endif

  function automatic logic [XW-1:0] init_x(input int unsigned i);
    return XW'(SCREEN_W + i * SPACING);
  endfunction

  function automatic logic [GW-1:0] init_gap(input int unsigned i);
    return GW'(GAP_MIN + 32 * i);
  endfunction

  // State register and all output-facing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < NUM_TUBES; i++) begin
        x_q[i]   <= init_x(i);
        gap_q[i] <= init_gap(i);
      end
      lfsr_q    <= LFSR_SEED;
      score_q   <= 8'd0;
      pass_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      score_q   <= score_d;
      pass_q    <= pass_d;
      running_q <= running_d;
    end
  end

  // Next-state, scrolling, wrap, pass detection and scoring.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    gap_d    = gap_q;
    lfsr_d   = lfsr_q;
    score_d  = score_q;
    pass_d   = 1'b0;
    any_pass = 1'b0;
`ifdef TUBE_SPEEDUP_EN
    speed_d  = speed_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (freeze_i) begin
          state_d = S_FROZEN;
        end else if (tick_i) begin
          for (int unsigned i = 0; i < NUM_TUBES; i++) begin
            if (x_q[i] < speed) begin
              x_d[i]   = x_q[i] + WRAP_ADD - speed;
              gap_d[i] = GW'(GAP_MIN) + GW'(lfsr_q[6:0]);
            end else begin
              x_d[i] = x_q[i] - speed;
              if ((XW1'(x_q[i]) + TUBE_W_X > BIRD_X_X) &&
                  (XW1'(x_d[i]) + TUBE_W_X <= BIRD_X_X))
                any_pass = 1'b1;
            end
          end
          lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
          if (any_pass) begin
            pass_d = 1'b1;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
`ifdef TUBE_SPEEDUP_EN
              if ((score_d[2:0] == 3'd0) && (speed_q < MAX_SPEED_X))
                speed_d = speed_q + XW'(1);
`endif
            end
          end
        end
      end
      S_FROZEN: begin
        if (start_i) begin
          state_d = S_RUN;
          for (int unsigned i = 0; i < NUM_TUBES; i++) begin
            x_d[i]   = init_x(i);
            gap_d[i] = init_gap(i);
          end
          score_d = 8'd0;
`ifdef TUBE_SPEEDUP_EN
          speed_d = SPEED_X;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  // Pack per-tube registers onto the flat output buses.
  for (genvar g = 0; g < NUM_TUBES; g++) begin : g_pack
    assign tube_x_o[g*XW +: XW] = x_q[g];
    assign gap_y_o[g*GW +: GW]  = gap_q[g];
  end

  assign pass_o    = pass_q;
  assign score_o   = score_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_tube_field.sv
// Testbench for tube_field: directed scenarios plus random stimulus, with
// expected outputs from a behavioural model pushed to a scoreboard queue.
module tb_tube_field;

  localparam int N         = 4;
  localparam int XW        = 11;
  localparam int SCREEN_W  = 640;
  localparam int SPACING   = 200;
  localparam int TUBE_W    = 60;
  localparam int GAP_MIN   = 80;
  localparam int BIRD_X    = 160;
  localparam int SPEED     = 2;
  localparam int MAX_SPEED = 6;
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_FROZEN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic freeze = 1'b0;
  logic [N*XW-1:0] tube_x;
  logic [N*9-1:0]  gap_y;
  logic            pass;
  logic [7:0]      score;
  logic            running;

  tube_field dut (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (tick),
    .start_i  (start),
    .freeze_i (freeze),
    .tube_x_o (tube_x),
    .gap_y_o  (gap_y),
    .pass_o   (pass),
    .score_o  (score),
    .running_o(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*XW-1:0] tx;
    logic [N*9-1:0]  gy;
    logic            ps;
    logic [7:0]      sc;
    logic            rn;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Behavioural game model
  int          m_x[N];
  int          m_gap[N];
  int          m_score;
  int          m_speed;
  int          m_mode;
  int unsigned m_lfsr;
  bit          m_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_init(input bit full);
    for (int i = 0; i < N; i++) begin
      m_x[i]   = SCREEN_W + i * SPACING;
      m_gap[i] = GAP_MIN + 32 * i;
    end
    m_score = 0;
    m_speed = SPEED;
    if (full) begin
      m_lfsr = 32'hACE1;
      m_mode = M_IDLE;
    end
  endfunction

  function automatic void model_move();
    int nx;
    int sample;
    bit scored;
    sample = GAP_MIN + int'(m_lfsr % 128);
    scored = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_x[i] < m_speed) begin
        m_x[i]   = m_x[i] + N * SPACING - m_speed;
        m_gap[i] = sample;
      end else begin
        nx = m_x[i] - m_speed;
        if ((m_x[i] + TUBE_W > BIRD_X) && (nx + TUBE_W <= BIRD_X)) scored = 1'b1;
        m_x[i] = nx;
      end
    end
    m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 32'hB400 : 32'h0);
    if (scored) begin
      m_pass = 1'b1;
      if (m_score < 255) begin
        m_score++;
`ifdef TUBE_SPEEDUP_EN
        if ((m_score % 8 == 0) && (m_speed < MAX_SPEED)) m_speed++;
`endif
      end
    end
  endfunction

  function automatic exp_t model_pack();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.tx[i*XW +: XW] = XW'(m_x[i]);
      e.gy[i*9 +: 9]   = 9'(m_gap[i]);
    end
    e.ps = m_pass;
    e.sc = 8'(m_score);
    e.rn = (m_mode == M_RUN);
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic cycle(input bit r, input bit t, input bit s, input bit f);
    bit   rose;
    exp_t e;
    @(negedge clk);
    rose   = r && !rst;
    rst    = r;
    tick   = t;
    start  = s;
    freeze = f;
    m_pass = 1'b0;
    if (r) begin
      model_init(1'b1);
    end else begin
      case (m_mode)
        M_IDLE:   if (s) m_mode = M_RUN;
        M_RUN:    if (f) m_mode = M_FROZEN; else if (t) model_move();
        M_FROZEN: if (s) begin model_init(1'b0); m_mode = M_RUN; end
        default:  m_mode = M_IDLE;
      endcase
    end
    e = model_pack();
    sb.push_back(e);
    if (rose) begin
      #1;
      chk("async_rst_running", 64'(running), 64'(0));
      chk("async_rst_pass", 64'(pass), 64'(0));
      chk("async_rst_tube_x", 64'(tube_x), 64'(e.tx));
    end
  endtask

  // Scoreboard monitor: compare every registered output after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_tube_x", 64'(tube_x), 64'(e.tx));
        chk("sb_gap_y", 64'(gap_y), 64'(e.gy));
        chk("sb_pass", 64'(pass), 64'(e.ps));
        chk("sb_score", 64'(score), 64'(e.sc));
        chk("sb_running", 64'(running), 64'(e.rn));
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, t, s, f;
    model_init(1'b1);
    m_pass = 1'b0;

    // Reset, then ticks in IDLE must change nothing.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
    @(posedge clk); #2;
    chk("idle_tube_x", 64'(tube_x), 64'({11'd1240, 11'd1040, 11'd840, 11'd640}));
    chk("idle_gap_y", 64'(gap_y), 64'({9'd176, 9'd144, 9'd112, 9'd80}));
    chk("idle_running", 64'(running), 64'(0));
    chk("idle_score", 64'(score), 64'(0));

    // Start, then ten ticks separated by idle cycles.
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
    end
    @(posedge clk); #2;
    chk("run10_tube0", 64'(tube_x[10:0]), 64'(620));
    chk("run10_tube3", 64'(tube_x[43:33]), 64'(1220));
    chk("run10_running", 64'(running), 64'(1));

    // Freeze beats a same-cycle tick; later ticks ignored; start reloads.
    cycle(0, 1, 0, 1);
    @(posedge clk); #2;
    chk("freeze_running", 64'(running), 64'(0));
    chk("freeze_tube0", 64'(tube_x[10:0]), 64'(620));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    @(posedge clk); #2;
    chk("frozen_tube0", 64'(tube_x[10:0]), 64'(620));
    cycle(0, 0, 1, 0);
    @(posedge clk); #2;
    chk("restart_tube_x", 64'(tube_x), 64'({11'd1240, 11'd1040, 11'd840, 11'd640}));
    chk("restart_score", 64'(score), 64'(0));
    chk("restart_running", 64'(running), 64'(1));

    // Random play: frequent ticks, rare freeze/reset, start often.
    for (int i = 0; i < 12000; i++) begin
      r = ($urandom_range(0, 4999) == 0) || (i == 6000);
      t = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 2999) == 0);
      cycle(r, t, s, f);
    end

    // Long uninterrupted run from a fresh game to reach score saturation.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 26200; i++) cycle(0, 1, 0, 0);
    @(posedge clk); #2;
    chk("score_saturated", 64'(score), 64'(255));

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(posedge clk); #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
